// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
// Imported by the loader, its BRAM and the testbench.
package constant;

    localparam int INST_ADDR_W = 15;

    typedef enum logic [1:0] {
        HDR,
        BODY,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Received-byte stream from uart_rx into the loader.
// master drives bytes, slave (the loader) consumes them.
interface imem_loader_if;

    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ferr;

    modport master (
        output rx_data,
        output rx_ready,
        output rx_ferr
    );

    modport slave (
        input rx_data,
        input rx_ready,
        input rx_ferr
    );

endinterface

// File: rtl/imem_bram.sv
// Simple dual-port instruction RAM, one write and one read port.
// Read-first with a registered output; contents survive reset.
module imem_bram
    import constant::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Write port: storage array is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register with sync reset, old data on collision.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program from the UART byte
// stream into instruction RAM, then serves one word per cycle.
module imem_loader
    import constant::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    imem_loader_if.slave      rx,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    loader_state_t state;
    loader_state_t state_d;

    logic [31:0] asm_q;
    logic [1:0]  byte_cnt;
    logic [31:0] rem_q;

    logic        live;
    logic        acc;
    logic        ferr_hit;
    logic        word_end;
    logic [31:0] word;
    logic        full;
    logic        we;

    logic [ADDR_W-1:0] raddr;
    logic              unused_pc;

    assign live     = (state != DONE);
    assign acc      = live && rx.rx_ready && !rx.rx_ferr;
    assign ferr_hit = live && rx.rx_ready && rx.rx_ferr;
    assign word_end = acc && (byte_cnt == 2'd3);
    assign word     = {asm_q[23:0], rx.rx_data};
    assign full     = word_cnt[ADDR_W];
    assign we       = word_end && (state == BODY) && !full;

    assign done      = (state == DONE);
    assign raddr     = pc[ADDR_W+1:2];
    assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= HDR;
        end else begin
            state <= state_d;
        end
    end

    // Next state: header decides empty vs body, body ends on count.
    always_comb begin
        state_d = state;
        unique case (state)
            HDR: begin
                if (word_end) begin
                    state_d = (word == 32'd0) ? DONE : BODY;
                end
            end
            BODY: begin
                if (word_end && (rem_q == 32'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    // Byte assembly, counters and sticky error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            asm_q    <= '0;
            byte_cnt <= '0;
            rem_q    <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (ferr_hit) begin
                err <= 1'b1;
            end
            if (acc) begin
                asm_q    <= word;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_end && (state == HDR)) begin
                rem_q <= word;
            end
            if (word_end && (state == BODY)) begin
                rem_q <= rem_q - 32'd1;
                if (full) begin
                    err <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
        end
    end

    imem_bram #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .waddr (word_cnt[ADDR_W-1:0]),
        .wdata (word),
        .raddr (raddr),
        .rdata (inst)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader, using a full-depth
// instance and a 4-word instance for overflow behaviour.
module tb_imem_loader;
    import constant::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_ferr;
    logic [31:0] pc;

    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic        done_a;
    logic        done_b;
    logic        err_a;
    logic        err_b;
    logic [15:0] wc_a;
    logic [2:0]  wc_b;

    logic [31:0] inst_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] wc_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_loader_if ifa ();
    imem_loader_if ifb ();

    assign ifa.rx_data  = rx_data;
    assign ifa.rx_ready = rx_ready & ~sel;
    assign ifa.rx_ferr  = rx_ferr;
    assign ifb.rx_data  = rx_data;
    assign ifb.rx_ready = rx_ready & sel;
    assign ifb.rx_ferr  = rx_ferr;

    imem_loader #(.ADDR_W(15)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (ifa.slave),
        .pc       (pc),
        .inst     (inst_a),
        .done     (done_a),
        .err      (err_a),
        .word_cnt (wc_a)
    );

    imem_loader #(.ADDR_W(2)) dut_s (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (ifb.slave),
        .pc       (pc),
        .inst     (inst_b),
        .done     (done_b),
        .err      (err_b),
        .word_cnt (wc_b)
    );

    assign inst_o = sel ? inst_b : inst_a;
    assign done_o = sel ? done_b : done_a;
    assign err_o  = sel ? err_b : err_a;
    assign wc_o   = sel ? {29'd0, wc_b} : {16'd0, wc_a};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rx_data  = b;
        rx_ferr  = fe;
        rx_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_ready = 1'b0;
            rx_ferr  = 1'b0;
        end
    endtask

    task automatic put_word(input logic [31:0] w);
        put(w[31:24], 1'b0);
        put(w[23:16], 1'b0);
        put(w[15:8], 1'b0);
        put(w[7:0], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
        @(negedge clk);
        rx_ready = 1'b0;
        pc       = a;
        @(negedge clk);
        chk(tag, inst_o, exp);
    endtask

    // Model: the stream is header N then N words; memory holds the
    // first min(N, depth) words; err if any bad frame or N > depth.
    task automatic rand_load(input int n, input int depth,
                             input bit fe_ok, input int maxgap);
        logic [31:0] w [$];
        logic [7:0]  bq [$];
        logic [31:0] hdr;
        bit          fe_seen;
        int          kept;
        logic [31:0] a;
        fe_seen = 1'b0;
        hdr = n;
        for (int k = 3; k >= 0; k--) begin
            bq.push_back(hdr[8*k +: 8]);
        end
        for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            for (int k = 3; k >= 0; k--) begin
                bq.push_back(w[i][8*k +: 8]);
            end
        end
        for (int i = 0; i < bq.size(); i++) begin
            if (fe_ok && ($urandom_range(0, 7) == 0)) begin
                put(8'($urandom), 1'b1);
                fe_seen = 1'b1;
            end
            put(bq[i], 1'b0);
            if (i == bq.size() - 1) begin
                chk("rand_pre_done", {31'd0, done_o}, 32'd0);
            end else begin
                idle($urandom_range(0, maxgap));
            end
        end
        idle(1);
        kept = (n < depth) ? n : depth;
        chk("rand_done", {31'd0, done_o}, 32'd1);
        chk("rand_wc", wc_o, kept);
        chk("rand_err", {31'd0, err_o},
            {31'd0, (fe_seen || (n > depth))});
        for (int i = 0; i < kept; i++) begin
            a = i * 4 + depth * 4 * $urandom_range(0, 3)
                + $urandom_range(0, 3);
            rd(a, w[i], $sformatf("rand_word%0d", i));
        end
    endtask

    initial begin
        logic [7:0] body [8];
        body = '{8'h11, 8'h22, 8'h33, 8'h44,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rstn     = 1'b0;
        sel      = 1'b0;
        rx_data  = '0;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        pc       = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // reset state
        do_reset();
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_wc", wc_o, 32'd0);

        // slow two-word load
        put_word(32'd2);
        idle(100);
        for (int i = 0; i < 8; i++) begin
            put(body[i], 1'b0);
            if (i == 7) begin
                chk("slow_pre_done", {31'd0, done_o}, 32'd0);
            end else begin
                idle(100);
            end
        end
        idle(1);
        chk("slow_done", {31'd0, done_o}, 32'd1);
        chk("slow_wc", wc_o, 32'd2);
        rd(32'd0, 32'h11223344, "slow_pc0");
        rd(32'd4, 32'hAABBCCDD, "slow_pc4");
        rd(32'd6, 32'hAABBCCDD, "slow_pc6");

        // empty program, later bytes ignored
        do_reset();
        put_word(32'd0);
        chk("zero_pre_done", {31'd0, done_o}, 32'd0);
        idle(1);
        chk("zero_done", {31'd0, done_o}, 32'd1);
        chk("zero_wc", wc_o, 32'd0);
        chk("zero_err", {31'd0, err_o}, 32'd0);
        put_word(32'hFFFFFFFF);
        put(8'h55, 1'b1);
        put_word(32'h00000001);
        idle(2);
        chk("zero_after_wc", wc_o, 32'd0);
        chk("zero_after_err", {31'd0, err_o}, 32'd0);
        chk("zero_after_done", {31'd0, done_o}, 32'd1);

        // back-to-back bytes
        do_reset();
        rand_load(2, 32768, 1'b0, 0);

        // framing error then resend
        do_reset();
        put_word(32'd1);
        put(8'h11, 1'b0);
        put(8'hEE, 1'b1);
        put(8'h22, 1'b0);
        put(8'h33, 1'b0);
        put(8'h44, 1'b0);
        idle(1);
        chk("ferr_err", {31'd0, err_o}, 32'd1);
        chk("ferr_done", {31'd0, done_o}, 32'd1);
        chk("ferr_wc", wc_o, 32'd1);
        rd(32'd0, 32'h11223344, "ferr_word0");

        // depth overflow on the 4-word instance
        sel = 1'b1;
        do_reset();
        put_word(32'd5);
        for (int i = 1; i <= 5; i++) begin
            put_word(i);
        end
        idle(1);
        chk("ovf_err", {31'd0, err_o}, 32'd1);
        chk("ovf_wc", wc_o, 32'd4);
        chk("ovf_done", {31'd0, done_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(i * 4, i + 1, $sformatf("ovf_addr%0d", i));
        end
        rd(32'd16, 32'd1, "ovf_wrap");
        sel = 1'b0;

        // reset in the middle of a load
        do_reset();
        put_word(32'd2);
        put(8'h01, 1'b0);
        put(8'h02, 1'b1);
        put(8'h02, 1'b0);
        put(8'h03, 1'b0);
        put(8'h04, 1'b0);
        put(8'h05, 1'b0);
        put(8'h06, 1'b0);
        idle(1);
        chk("mid_err_before", {31'd0, err_o}, 32'd1);
        chk("mid_done_before", {31'd0, done_o}, 32'd0);
        do_reset();
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        chk("mid_rst_err", {31'd0, err_o}, 32'd0);
        chk("mid_rst_wc", wc_o, 32'd0);
        put_word(32'd1);
        put_word(32'hCAFEBABE);
        idle(1);
        chk("mid_done", {31'd0, done_o}, 32'd1);
        chk("mid_wc", wc_o, 32'd1);
        rd(32'd0, 32'hCAFEBABE, "mid_pc0");

        // randomized loads
        for (int t = 0; t < 4; t++) begin
            do_reset();
            rand_load($urandom_range(0, 6), 32768, 1'b1, 2);
        end
        sel = 1'b1;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            rand_load($urandom_range(1, 7), 4, 1'b1, 1);
        end
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
